// File: rtl/pe_bram_responder_if.sv
// Engine, host and run-control signals between the PE array / host side and the BRAM responder.
interface pe_bram_responder_if #(
    parameter int DEPTH_LOG = 8,
    parameter int CNT_W     = 16
);
    logic [31:0]          bram_addr;
    logic [31:0]          bram_wrdata;
    logic [3:0]           bram_we;
    logic [31:0]          bram_rddata;
    logic [DEPTH_LOG-1:0] host_addr;
    logic [31:0]          host_wrdata;
    logic                 host_we;
    logic                 host_re;
    logic [31:0]          host_rddata;
    logic                 host_rvalid;
    logic                 host_busy;
    logic                 host_go;
    logic                 start;
    logic                 done;
    logic                 run_done;
    logic                 err_oor;
    logic [CNT_W-1:0]     wr_count;

    modport master (
        output bram_addr, bram_wrdata, bram_we, host_addr, host_wrdata,
               host_we, host_re, host_go, done,
        input  bram_rddata, host_rddata, host_rvalid, host_busy, start,
               run_done, err_oor, wr_count
    );

    modport slave (
        input  bram_addr, bram_wrdata, bram_we, host_addr, host_wrdata,
               host_we, host_re, host_go, done,
        output bram_rddata, host_rddata, host_rvalid, host_busy, start,
               run_done, err_oor, wr_count
    );
endinterface

// File: rtl/pe_bram_responder.sv
// Word memory shared by the host preload port and the PE-array engine port,
// plus the start/done run sequencer that decides which side owns it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | host port owns memory; host_go launches a run
// S_START | one-cycle start pulse to the array; run statistics cleared
// S_RUN   | engine port owns memory; done moves to drain
// S_DRAIN | RD_LAT cycles for in-flight reads; run_done on the last one
module pe_bram_responder #(
    parameter int DEPTH_LOG = 8,
    parameter int RD_LAT    = 1,
    parameter int CNT_W     = 16
) (
    input  logic               aclk,
    input  logic               aresetn,
    pe_bram_responder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DRAIN} state_t;

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
            $error("pe_bram_responder: RD_LAT must be 1 or 2");
        end
    endgenerate

    state_t               state, state_nxt;
    logic [1:0]           drain_cnt, drain_cnt_nxt;
    logic                 start_c, run_done_c, busy_c;

    logic [31:0]          mem [DEPTH];
    logic [31:0]          mem_q;

    logic                 eng_active, host_active, eng_legal;
    logic                 eng_wr, host_wr, host_rd;
    logic [DEPTH_LOG-1:0] eng_idx, rd_idx, wr_idx;
    logic [31:0]          wr_data;
    logic [3:0]           wr_mask;

    logic                 eng_v1, eng_ok1;
    logic [31:0]          eng_s1, lat_q, eng_out;
    logic                 host_rvalid_q;
    logic [CNT_W-1:0]     wr_count_q;
    logic                 err_oor_q;

    assign eng_active  = (state == S_RUN) || (state == S_DRAIN);
    assign host_active = (state == S_IDLE);
    assign eng_idx     = bus.bram_addr[DEPTH_LOG+1:2];
    assign eng_legal   = (bus.bram_addr[1:0] == 2'b00) &&
                         (bus.bram_addr[31:DEPTH_LOG+2] == '0);
    assign eng_wr      = eng_active && eng_legal && (bus.bram_we != 4'b0000);
    assign host_wr     = host_active && bus.host_we;
    assign host_rd     = host_active && bus.host_re;

    // The FSM never lets both sides in at once, so one read and one write port suffice.
    assign rd_idx  = host_active ? bus.host_addr : eng_idx;
    assign wr_idx  = host_active ? bus.host_addr : eng_idx;
    assign wr_data = host_active ? bus.host_wrdata : bus.bram_wrdata;
    assign wr_mask = !aresetn ? 4'h0 : (host_wr ? 4'hF : (eng_wr ? bus.bram_we : 4'h0));

    always_ff @(posedge aclk) begin
        mem_q <= mem[rd_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            eng_v1        <= 1'b0;
            eng_ok1       <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            eng_v1        <= eng_active;
            eng_ok1       <= eng_active && eng_legal;
            host_rvalid_q <= host_rd;
        end
    end

    assign eng_s1 = eng_ok1 ? mem_q : 32'h0;

    generate
        if (RD_LAT == 2) begin : g_lat2
            always_ff @(posedge aclk) begin
                if (!aresetn || state == S_START) lat_q <= 32'h0;
                else if (eng_v1)                  lat_q <= eng_s1;
            end
            assign eng_out = lat_q;
        end else begin : g_lat1
            // lat_q only remembers the last result so the port holds between reads.
            always_ff @(posedge aclk) begin
                if (!aresetn || state == S_START) lat_q <= 32'h0;
                else                              lat_q <= eng_out;
            end
            assign eng_out = eng_v1 ? eng_s1 : lat_q;
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_count_q <= '0;
            err_oor_q  <= 1'b0;
        end else if (state == S_IDLE && bus.host_go) begin
            wr_count_q <= '0;
            err_oor_q  <= 1'b0;
        end else if (eng_active) begin
            if (!eng_legal) err_oor_q <= 1'b1;
            if (eng_wr && wr_count_q != '1) wr_count_q <= wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        start_c       = 1'b0;
        run_done_c    = 1'b0;
        busy_c        = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.host_go) state_nxt = S_START;
            end
            S_START: begin
                start_c   = 1'b1;
                busy_c    = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                busy_c = 1'b1;
                if (bus.done) begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = 2'(RD_LAT - 1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt == 2'd0) begin
                    run_done_c = 1'b1;
                    state_nxt  = S_IDLE;
                end else begin
                    busy_c        = 1'b1;
                    drain_cnt_nxt = drain_cnt - 2'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.bram_rddata = eng_active ? eng_out : 32'h0;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rddata = host_rvalid_q ? mem_q : 32'h0;
    assign bus.host_busy   = busy_c;
    assign bus.start       = start_c;
    assign bus.run_done    = run_done_c;
    assign bus.err_oor     = err_oor_q;
    assign bus.wr_count    = wr_count_q;
endmodule

// File: doc/pe_bram_responder.md
Name: pe_bram_responder

Overview:
Memory-side responder for the PE-array BRAM port. It holds the vector, matrix and result words the array reads and writes. It also exposes a host port for preloading operands and reading back results, and it sequences the run handshake (start pulse out, done pulse in). It sits between the AXI-lite register block and the PE array, replacing an external BRAM controller in simulation and on small FPGA builds.

Parameters:
DEPTH_LOG, 8, log2 of memory depth in 32-bit words.
RD_LAT, 1, engine-port read latency in cycles; legal values 1 or 2, any other value is a synthesis error.
CNT_W, 16, width of the saturating write counter.

Ports:
aclk  in  1  clock, rising edge.
aresetn  in  1  synchronous active-low reset.
bram_addr  in  32  engine byte address.
bram_wrdata  in  32  engine write data.
bram_we  in  4  engine byte write enables.
bram_rddata  out  32  engine read data.
host_addr  in  DEPTH_LOG  host word address.
host_wrdata  in  32  host write data.
host_we  in  1  host write strobe, all 4 bytes.
host_re  in  1  host read strobe.
host_rddata  out  32  host read data.
host_rvalid  out  1  host read data valid, one-cycle pulse.
host_busy  out  1  high while the engine owns the memory.
host_go  in  1  request to launch a run.
start  out  1  one-cycle launch pulse to the PE array.
done  in  1  one-cycle completion pulse from the PE array.
run_done  out  1  one-cycle pulse when the run is fully drained.
err_oor  out  1  sticky flag: engine accessed a misaligned or out-of-range address.
wr_count  out  CNT_W  number of engine write cycles in the current or last run, saturating.

Behaviour:
- Reset (aresetn low at a rising edge): state=S_IDLE. The following outputs all go to 0: bram_rddata, host_rddata, host_rvalid, host_busy, start, run_done, err_oor, wr_count. Memory contents are not cleared.
- Synchronous reset asserted mid-run aborts the run immediately; pipeline stages are flushed to 0.
- FSM states:
  - S_IDLE: host port active. host_go -> S_START.
  - S_START: start=1 for exactly this cycle; wr_count and err_oor are cleared this cycle; host_busy=1. Next state is S_RUN.
  - S_RUN: engine port active; host_busy=1. done -> S_DRAIN.
  - S_DRAIN: held for RD_LAT cycles so in-flight reads complete. Then run_done=1 for one cycle and the FSM returns to S_IDLE. host_busy drops in that same cycle.
- Engine port is honoured only in S_RUN and S_DRAIN. In other states bram_we is ignored and bram_rddata=0.
- Engine address decode:
  - Word index = bram_addr[DEPTH_LOG+1:2].
  - Illegal if bram_addr[1:0]!=0 or any bit of bram_addr[31:DEPTH_LOG+2] is set.
  - An illegal access sets err_oor, suppresses the write, and returns 0 for the read.
- Engine write: for each byte b, if bram_we[b]=1, bits [8b+7:8b] are written at the clock edge. Partial-byte writes are legal.
- wr_count increments on each legal engine cycle with bram_we!=0 and saturates at all-ones.
- Engine read:
  - Issued every engine-active cycle, read-first: data is sampled before a same-cycle write.
  - Data appears on bram_rddata RD_LAT cycles after the address (RD_LAT=1: the cycle after; RD_LAT=2: one more register stage).
  - bram_rddata holds its value until a newer read result arrives.
- Host port (S_IDLE only):
  - host_we writes the full word.
  - host_re: host_rddata is valid with host_rvalid=1 exactly 1 cycle later.
  - host_we and host_re in the same cycle: write wins; the read returns the old data, read-first.
  - Host strobes while host_busy=1 are dropped: no write, no host_rvalid.
- host_go outside S_IDLE is ignored. done outside S_RUN is ignored.
- done arriving in S_START is ignored; the array is not launched yet.
- Single memory array, one read port and one write port. The FSM guarantees host and engine never access it in the same cycle.

Test Plan:
1. Reset -> all outputs 0. Host write addr 5 = 0xDEADBEEF, then host read addr 5 -> host_rvalid after 1 cycle with host_rddata=0xDEADBEEF.
2. host_go -> start high for exactly 1 cycle, host_busy=1. Engine read of byte address 0x14 (RD_LAT=1) -> bram_rddata=0xDEADBEEF on the next cycle.
3. In S_RUN, engine writes 0x11223344 to 0x20 with bram_we=4'b0011 over prior word 0xAAAAAAAA -> memory holds 0xAAAA3344; wr_count=1. Read-first check on the same cycle returns 0xAAAAAAAA.
4. In S_RUN, engine access at 0x0000_0402 (misaligned) and at 0x0000_0400 (out of range for DEPTH_LOG=8) -> err_oor=1 and stays set; no memory change; bram_rddata=0.
5. done pulse with RD_LAT=2 -> run_done occurs 2 cycles later; a host_we issued during S_DRAIN is dropped and the target word is unchanged.
6. aresetn low during S_RUN -> S_IDLE next cycle, all outputs 0; memory contents preserved, confirmed by host readback. 70000 engine writes with CNT_W=16 -> wr_count=0xFFFF.
